// File: rtl/touch_adc_seq.sv
// Touch-panel ADC sequencer: frames up to four XPT2046/ADS7843 conversions per pen-down.
// Optional build macro TOUCH_ADC_SEQ_AVG_EN: four back-to-back conversions per channel, averaged.
module touch_adc_seq #(
  parameter int NUM_CH      = 2,
  parameter int DATA_W      = 12,
  parameter int CLK_DIV     = 4,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              EN,
  input  logic              ADC_PENIRQ_n,
  input  logic              ADC_DOUT,
  output logic              ADC_CS,
  output logic              ADC_DCLK,
  output logic              ADC_DIN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [1:0]        CH_OUT,
  output logic              DATA_VALID,
  output logic              FRAME_DONE,
  output logic              BUSY
);

`ifdef TOUCH_ADC_SEQ_AVG_EN
  localparam int CONV_PER_CH = 4;
  localparam int CONV_W      = 4;
`else
  localparam int CONV_PER_CH = 1;
  localparam int CONV_W      = 2;
`endif
  localparam int TOTAL_CONV = NUM_CH * CONV_PER_CH;
  localparam int PH_W       = $clog2(2 * CLK_DIV);
  localparam int HOLD_W     = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic MODE     = (DATA_W == 8);

  localparam logic [4:0] LAST_PERIOD = 5'd23;
  localparam logic [4:0] FIRST_READ  = 5'd9;
  localparam logic [4:0] LAST_READ   = 5'(8 + DATA_W);
  localparam logic [4:0] CMD_BITS    = 5'd8;

  if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
    $error("touch_adc_seq: NUM_CH must be 1..4");
  end
  if (DATA_W != 8 && DATA_W != 12) begin : g_bad_data_w
    $error("touch_adc_seq: DATA_W must be 8 or 12");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("touch_adc_seq: CLK_DIV must be >= 2");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("touch_adc_seq: IDLE_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, HOLD} state_t;

  state_t              state;
  logic                pen_meta;
  logic                pen_sync;
  logic [PH_W-1:0]     ph;
  logic [4:0]          period;
  logic [CONV_W-1:0]   conv;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DATA_W-1:0]   shreg;
  logic                finishing;

  logic [CONV_W-1:0]   conv_nxt;
  logic [4:0]          period_nxt;
  logic                last_conv;
  logic [1:0]          ch_cur;
  logic                ch_done;
  logic [DATA_W-1:0]   result;
  logic [7:0]          cmd_cur;
`ifdef TOUCH_ADC_SEQ_AVG_EN
  logic [DATA_W+1:0]   sum;
  logic [DATA_W+1:0]   sum_new;
`endif

  function automatic logic [7:0] cmd_byte(input logic [1:0] ch);
    logic [2:0] addr;
    case (ch)
      2'd0:    addr = 3'b101;
      2'd1:    addr = 3'b001;
      2'd2:    addr = 3'b011;
      default: addr = 3'b100;
    endcase
    return {1'b1, addr, MODE, 1'b0, 2'b00};
  endfunction

  // Pen-down is asynchronous to CLK; two flops, idle state is pen up.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pen_meta <= 1'b1;
      pen_sync <= 1'b1;
    end else begin
      pen_meta <= ADC_PENIRQ_n;
      pen_sync <= pen_meta;
    end
  end

  always_comb begin
    conv_nxt   = conv + CONV_W'(1);
    period_nxt = period + 5'd1;
    last_conv  = (conv == CONV_W'(TOTAL_CONV - 1));
`ifdef TOUCH_ADC_SEQ_AVG_EN
    ch_cur  = conv[3:2];
    sum_new = ((conv[1:0] == 2'd0) ? '0 : sum) + {2'b00, shreg};
    ch_done = (conv[1:0] == 2'd3);
    result  = sum_new[DATA_W+1:2];
`else
    ch_cur  = conv;
    ch_done = 1'b1;
    result  = shreg;
`endif
    cmd_cur = cmd_byte(ch_cur);
  end

  // One DCLK period is 2*CLK_DIV cycles: ph counts within it, period counts 0..23 per conversion.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      ph         <= '0;
      period     <= '0;
      conv       <= '0;
      hold_cnt   <= '0;
      shreg      <= '0;
      finishing  <= 1'b0;
      ADC_CS     <= 1'b0;
      ADC_DCLK   <= 1'b0;
      ADC_DIN    <= 1'b0;
      DATA_OUT   <= '0;
      CH_OUT     <= 2'd0;
      DATA_VALID <= 1'b0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
`ifdef TOUCH_ADC_SEQ_AVG_EN
      sum        <= '0;
`endif
    end else begin
      DATA_VALID <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (EN) state <= ARMED;
        end
        ARMED: begin
          if (!EN) begin
            state <= IDLE;
          end else if (!pen_sync) begin
            state     <= SHIFT;
            BUSY      <= 1'b1;
            ADC_CS    <= 1'b1;
            ADC_DCLK  <= 1'b0;
            ADC_DIN   <= 1'b1;
            ph        <= '0;
            period    <= '0;
            conv      <= '0;
            finishing <= 1'b0;
          end
        end
        SHIFT: begin
          if (finishing) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            finishing <= 1'b0;
          end else begin
            if (ph == PH_W'(CLK_DIV - 1)) ADC_DCLK <= 1'b1;
            if (ph == PH_W'(CLK_DIV) && period >= FIRST_READ && period <= LAST_READ)
              shreg <= {shreg[DATA_W-2:0], ADC_DOUT};
            if (ph == PH_W'(2 * CLK_DIV - 1)) begin
              ph       <= '0;
              ADC_DCLK <= 1'b0;
              if (period == LAST_PERIOD) begin
                period <= '0;
`ifdef TOUCH_ADC_SEQ_AVG_EN
                sum    <= sum_new;
`endif
                if (ch_done) begin
                  DATA_VALID <= 1'b1;
                  DATA_OUT   <= result;
                  CH_OUT     <= ch_cur;
                end
                if (last_conv) begin
                  FRAME_DONE <= 1'b1;
                  ADC_CS     <= 1'b0;
                  ADC_DIN    <= 1'b0;
                  finishing  <= 1'b1;
                end else begin
                  // Every command byte starts with the start bit, so the next channel's first bit is 1.
                  conv    <= conv_nxt;
                  ADC_DIN <= 1'b1;
                end
              end else begin
                period  <= period_nxt;
                ADC_DIN <= (period_nxt < CMD_BITS) ? cmd_cur[~period_nxt[2:0]] : 1'b0;
              end
            end else begin
              ph <= ph + PH_W'(1);
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(IDLE_CYCLES - 1)) begin
            state <= EN ? ARMED : IDLE;
            BUSY  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_adc_seq.sv
// Scoreboard bench for touch_adc_seq: a bit-level ADC model answers the serial frame,
// expected results are queued by the stimulus and popped by a monitor on DATA_VALID.
module tb_touch_adc_seq;
  localparam int NUM_CH      = 2;
  localparam int DATA_W      = 12;
  localparam int CLK_DIV     = 2;
  localparam int IDLE_CYCLES = 10;
`ifdef TOUCH_ADC_SEQ_AVG_EN
  localparam int CPC = 4;
`else
  localparam int CPC = 1;
`endif
  localparam int CONV_CYC = 48 * CLK_DIV;
  // Averaged X: (100+101+102+104)>>2 = 407>>2 = 101.
  localparam int EXP_X = (CPC == 1) ? 32'hABC : 101;
  localparam int EXP_Y = 32'h123;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic EN = 1'b0;
  logic ADC_PENIRQ_n = 1'b1;
  logic ADC_DOUT = 1'b0;
  logic ADC_CS, ADC_DCLK, ADC_DIN, DATA_VALID, FRAME_DONE, BUSY;
  logic [DATA_W-1:0] DATA_OUT;
  logic [1:0] CH_OUT;

  touch_adc_seq #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .ADC_PENIRQ_n(ADC_PENIRQ_n), .ADC_DOUT(ADC_DOUT),
    .ADC_CS(ADC_CS), .ADC_DCLK(ADC_DCLK), .ADC_DIN(ADC_DIN), .DATA_OUT(DATA_OUT),
    .CH_OUT(CH_OUT), .DATA_VALID(DATA_VALID), .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int data;
    bit fd;
    int offset;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  int p = -1;
  int t_cs = 0;
  int cs_rises = 0;
  int din_bad = 0;
  logic cs_q = 1'b0;
  logic dclk_q = 1'b0;
  logic [7:0] cmd_cap = 8'h00;
  int conv_word[16];

  always @(posedge CLK) cyc++;

  task automatic check_output(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int ch, input int data, input bit fd, input int offset);
    exp_t e;
    e.ch = ch; e.data = data; e.fd = fd; e.offset = offset;
    sb.push_back(e);
  endtask

  // ADC model: reacts at the negedge after each DCLK rise, ahead of the DUT's sampling edge.
  always @(negedge CLK) begin
    if (!RST_n) begin
      p = -1; cs_q = 1'b0; dclk_q = 1'b0; ADC_DOUT = 1'b0;
    end else begin
      if (ADC_CS && !cs_q) begin
        p = -1; t_cs = cyc; cs_rises++;
      end
      if (ADC_DCLK && !dclk_q) begin
        int q, r, cv;
        logic [11:0] w;
        p++;
        cv = p / 24;
        q = p % 24;
        if (q < 8) begin
          cmd_cap = {cmd_cap[6:0], ADC_DIN};
          ADC_DOUT = 1'b0;
          if (q == 7) check_output("din_cmd", int'(cmd_cap), (cv / CPC == 0) ? 32'hD0 : 32'h90);
        end else begin
          if (ADC_DIN) din_bad++;
          r = q - 8;
          w = 12'(conv_word[cv]);
          ADC_DOUT = (r >= 1 && r <= DATA_W) ? w[DATA_W - r] : 1'b0;
        end
      end
      cs_q = ADC_CS;
      dclk_q = ADC_DCLK;
    end
  end

  // Monitor: every DATA_VALID must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (DATA_VALID) begin
        if (sb.size() == 0) begin
          tests_run++;
          fails++;
          $display("[TB] FAIL unexpected_valid: got ch %0d data 0x%0h, required no result", CH_OUT, DATA_OUT);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("ch_out", int'(CH_OUT), e.ch);
          check_output("data_out", int'(DATA_OUT), e.data);
          check_output("frame_done_flag", int'(FRAME_DONE), int'(e.fd));
          check_output("cs_at_valid", int'(ADC_CS), e.fd ? 0 : 1);
          check_output("valid_offset", cyc - t_cs, e.offset);
        end
      end else if (FRAME_DONE) begin
        tests_run++;
        fails++;
        $display("[TB] FAIL frame_done_alone: got FRAME_DONE=1, required DATA_VALID with it");
      end
    end
  end

  task automatic wait_frame_done(input string name);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge CLK);
      if (FRAME_DONE) found = 1'b1;
    end
    check_output(name, int'(found), 1);
  endtask

  task automatic wait_cs_rise(input string name, input int c0);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge CLK);
      if (cs_rises > c0) found = 1'b1;
    end
    check_output(name, int'(found), 1);
  endtask

  task automatic wait_period(input string name, input int k);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge CLK);
      if (p >= k) found = 1'b1;
    end
    check_output(name, int'(found), 1);
  endtask

  task automatic push_frame();
    push_exp(0, EXP_X, 1'b0, CONV_CYC * CPC);
    push_exp(1, EXP_Y, 1'b1, CONV_CYC * CPC * 2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise_at, c0, f1, cs_hi, dclk_hi, busy_hi;
    for (int i = 0; i < 16; i++) conv_word[i] = 0;
    if (CPC == 1) begin
      conv_word[0] = 32'hABC;
      conv_word[1] = 32'h123;
    end else begin
      conv_word[0] = 100; conv_word[1] = 101; conv_word[2] = 102; conv_word[3] = 104;
      for (int i = 4; i < 8; i++) conv_word[i] = 32'h123;
    end

    // Reset held with pen down and EN high: everything stays at zero.
    RST_n = 1'b0; EN = 1'b1; ADC_PENIRQ_n = 1'b0;
    repeat (3) @(negedge CLK);
    check_output("reset_outputs",
                 int'({ADC_CS, ADC_DCLK, ADC_DIN, DATA_OUT, CH_OUT, DATA_VALID, FRAME_DONE, BUSY}), 0);
    push_frame();
    @(negedge CLK);
    RST_n = 1'b1;
    // The release cycle counts as cycle 1.
    rise_at = 0;
    for (int k = 2; k <= 20 && rise_at == 0; k++) begin
      @(negedge CLK);
      if (ADC_CS) rise_at = k;
    end
    check_output("cs_after_reset_cycles", rise_at, 4);
    ADC_PENIRQ_n = 1'b1;
    wait_frame_done("frame1_done");
    repeat (IDLE_CYCLES) @(negedge CLK);
    check_output("busy_last_hold", int'(BUSY), 1);
    @(negedge CLK);
    check_output("busy_armed", int'(BUSY), 0);
    check_output("data_held", int'(DATA_OUT), EXP_Y);
    check_output("ch_held", int'(CH_OUT), 1);
    check_output("sb_drained_1", sb.size(), 0);

    // Pen up: armed forever, bus quiet.
    cs_hi = 0; dclk_hi = 0; busy_hi = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge CLK);
      if (ADC_CS) cs_hi++;
      if (ADC_DCLK) dclk_hi++;
      if (BUSY) busy_hi++;
    end
    check_output("idle_cs_high", cs_hi, 0);
    check_output("idle_dclk_high", dclk_hi, 0);
    check_output("idle_busy_high", busy_hi, 0);

    // Pen held down across two frames: re-arm spacing.
    push_frame();
    push_frame();
    c0 = cs_rises;
    ADC_PENIRQ_n = 1'b0;
    wait_frame_done("rearm_fd1");
    f1 = cyc;
    wait_cs_rise("rearm_cs2", c0 + 1);
    check_output("rearm_gap", t_cs - f1, IDLE_CYCLES + 2);
    ADC_PENIRQ_n = 1'b1;
    wait_frame_done("rearm_fd2");
    repeat (IDLE_CYCLES + 2) @(negedge CLK);
    check_output("sb_drained_2", sb.size(), 0);

    // EN dropped mid-frame: frame finishes, then idle despite pen still down.
    push_frame();
    c0 = cs_rises;
    ADC_PENIRQ_n = 1'b0;
    wait_cs_rise("endrop_cs", c0);
    wait_period("endrop_p5", 5);
    EN = 1'b0;
    wait_frame_done("endrop_fd");
    c0 = cs_rises;
    repeat (300) @(negedge CLK);
    check_output("endrop_no_frame", cs_rises - c0, 0);
    check_output("endrop_busy", int'(BUSY), 0);
    check_output("endrop_data_held", int'(DATA_OUT), EXP_Y);
    check_output("sb_drained_3", sb.size(), 0);

    // Reset during period 30 aborts the frame immediately.
    if (CPC == 1) push_exp(0, EXP_X, 1'b0, CONV_CYC);
    c0 = cs_rises;
    EN = 1'b1;
    wait_cs_rise("abort_cs", c0);
    wait_period("abort_p30", 30);
    check_output("abort_dclk_before", int'(ADC_DCLK), 1);
    RST_n = 1'b0;
    #1;
    check_output("abort_bus", int'({ADC_CS, ADC_DCLK, ADC_DIN}), 0);
    check_output("abort_data", int'({DATA_OUT, CH_OUT, BUSY}), 0);
    ADC_PENIRQ_n = 1'b1;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    repeat (300) @(negedge CLK);
    check_output("sb_drained_4", sb.size(), 0);
    check_output("din_zero_in_reads", din_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
